// File: rtl/gcn_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// gcn_fetch_scheduler
//
// Control sequencer for the GCN inference datapath. It fetches the weight
// columns, then for each feature row fetches the row, captures it, starts the
// multiply engine and waits for it. After the last row it walks the COO edge
// list and hands over to the argmax stage. No arithmetic is done here; the
// block only says which datapath register takes data_in and when.
//
// Optional feature macro: GCN_SCHED_PERF_EN
//   defined     : cycle_count counts busy cycles. It saturates at 16'hFFFF,
//                 clears when a start is accepted and holds in DONE.
//   not defined : cycle_count is tied to zero.
//
// Ports
//   clk, reset_n   rising-edge clock, asynchronous active-low reset
//   start          level request, only looked at in IDLE / DONE
//   mac_done       multiply engine finished, only looked at in MAC_WAIT
//   argmax_done    argmax finished, only looked at in ARG_WAIT
//   read_address   memory address (0 when no read is issued)
//   enable_read    read strobe; data_in is valid one cycle later
//   wt_we, wt_idx  write data_in into weight column wt_idx
//   feat_we        write data_in into feature row row_idx
//   row_idx        current feature row
//   mac_start      one-cycle pulse: compute row row_idx
//   coo_address    edge index, live while coo_valid
//   coo_valid      coo_address is live this cycle
//   argmax_start   one-cycle pulse
//   busy           high in every state except IDLE and DONE
//   done           high only in DONE
//   cycle_count    busy-cycle performance counter
// -----------------------------------------------------------------------------
module gcn_fetch_scheduler #(
  parameter int FEATURE_ROWS    = 6,
  parameter int WEIGHT_COLS     = 3,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int ADDRESS_WIDTH   = 13,
  parameter int WEIGHT_BASE     = 0,
  parameter int FEATURE_BASE    = 512,
  parameter int ROW_BW          = $clog2(FEATURE_ROWS),
  parameter int WT_BW           = $clog2(WEIGHT_COLS),
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     mac_done,
  input  logic                     argmax_done,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic                     enable_read,
  output logic                     wt_we,
  output logic [WT_BW-1:0]         wt_idx,
  output logic                     feat_we,
  output logic [ROW_BW-1:0]        row_idx,
  output logic                     mac_start,
  output logic [COO_BW-1:0]        coo_address,
  output logic                     coo_valid,
  output logic                     argmax_start,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              cycle_count
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH_WT   = 4'd1,
    S_FETCH_FEAT = 4'd2,
    S_CAPTURE    = 4'd3,
    S_MAC_REQ    = 4'd4,
    S_MAC_WAIT   = 4'd5,
    S_COO_WALK   = 4'd6,
    S_ARG_REQ    = 4'd7,
    S_ARG_WAIT   = 4'd8,
    S_DONE       = 4'd9
  } state_t;

  // Terminal index values come from the parameters, not from the counter
  // width, so non-power-of-two sizes stop at the right place.
  localparam logic [WT_BW-1:0]  WT_LAST  = WT_BW'(WEIGHT_COLS - 1);
  localparam logic [ROW_BW-1:0] ROW_LAST = ROW_BW'(FEATURE_ROWS - 1);
  localparam logic [COO_BW-1:0] COO_LAST = COO_BW'(COO_NUM_OF_COLS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WT_BW-1:0]    r_wt_cnt;
  logic [ROW_BW-1:0]   r_row;
  logic [COO_BW-1:0]   r_coo;
  logic                r_wt_we;
  logic [WT_BW-1:0]    r_wt_idx;
  logic                w_idle_or_done;

  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_nxt = S_FETCH_WT;
        else       w_state_nxt = r_state;
      end
      S_FETCH_WT: begin
        if (r_wt_cnt == WT_LAST) w_state_nxt = S_FETCH_FEAT;
        else                     w_state_nxt = S_FETCH_WT;
      end
      S_FETCH_FEAT: w_state_nxt = S_CAPTURE;
      S_CAPTURE:    w_state_nxt = S_MAC_REQ;
      S_MAC_REQ:    w_state_nxt = S_MAC_WAIT;
      S_MAC_WAIT: begin
        if (!mac_done)             w_state_nxt = S_MAC_WAIT;
        else if (r_row == ROW_LAST) w_state_nxt = S_COO_WALK;
        else                       w_state_nxt = S_FETCH_FEAT;
      end
      S_COO_WALK: begin
        if (r_coo == COO_LAST) w_state_nxt = S_ARG_REQ;
        else                   w_state_nxt = S_COO_WALK;
      end
      S_ARG_REQ: w_state_nxt = S_ARG_WAIT;
      S_ARG_WAIT: begin
        if (argmax_done) w_state_nxt = S_DONE;
        else             w_state_nxt = S_ARG_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Index counters and the delayed weight-write strobe. The weight write lags
  // its read by one cycle because memory data arrives one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wt_cnt <= '0;
      r_row    <= '0;
      r_coo    <= '0;
      r_wt_we  <= 1'b0;
      r_wt_idx <= '0;
    end else begin
      r_wt_we  <= (r_state == S_FETCH_WT);
      r_wt_idx <= (r_state == S_FETCH_WT) ? r_wt_cnt : '0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_wt_cnt <= '0;
            r_row    <= '0;
            r_coo    <= '0;
          end else begin
            r_wt_cnt <= r_wt_cnt;
          end
        end
        S_FETCH_WT: begin
          if (r_wt_cnt != WT_LAST) r_wt_cnt <= r_wt_cnt + WT_BW'(1);
          else                     r_wt_cnt <= r_wt_cnt;
        end
        S_MAC_WAIT: begin
          if (mac_done && (r_row != ROW_LAST)) r_row <= r_row + ROW_BW'(1);
          else                                 r_row <= r_row;
        end
        S_COO_WALK: begin
          if (r_coo != COO_LAST) r_coo <= r_coo + COO_BW'(1);
          else                   r_coo <= r_coo;
        end
        default: r_coo <= r_coo;
      endcase
    end
  end

  // Output decode from registered state and indices only.
  always_comb begin
    enable_read  = 1'b0;
    read_address = '0;
    feat_we      = 1'b0;
    mac_start    = 1'b0;
    coo_valid    = 1'b0;
    coo_address  = '0;
    argmax_start = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_FETCH_WT: begin
        enable_read  = 1'b1;
        read_address = ADDRESS_WIDTH'(WEIGHT_BASE) + ADDRESS_WIDTH'(r_wt_cnt);
      end
      S_FETCH_FEAT: begin
        enable_read  = 1'b1;
        read_address = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(r_row);
      end
      S_CAPTURE:  feat_we      = 1'b1;
      S_MAC_REQ:  mac_start    = 1'b1;
      S_COO_WALK: begin
        coo_valid   = 1'b1;
        coo_address = r_coo;
      end
      S_ARG_REQ:  argmax_start = 1'b1;
      S_DONE:     done         = 1'b1;
      default:    done         = 1'b0;
    endcase
    busy = !w_idle_or_done;
  end

  assign wt_we   = r_wt_we;
  assign wt_idx  = r_wt_idx;
  assign row_idx = r_row;

`ifdef GCN_SCHED_PERF_EN
  logic [15:0] r_cycle_count;

  // Busy-cycle counter: cleared on an accepted start, frozen in IDLE/DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle_count <= 16'd0;
    end else if (w_idle_or_done) begin
      if (start) r_cycle_count <= 16'd0;
      else       r_cycle_count <= r_cycle_count;
    end else if (r_cycle_count != 16'hFFFF) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end else begin
      r_cycle_count <= r_cycle_count;
    end
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = 16'd0;
`endif

endmodule

// File: tb/tb_gcn_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for gcn_fetch_scheduler. For each run a reference model
// turns the chosen per-row multiply latencies and argmax latency into the
// timeline of strobes the scheduler must produce, and queues them per output.
// A negedge monitor pops an entry whenever the DUT raises a strobe and
// compares cycle and value. The stimulus drives mac_done/argmax_done from the
// same timeline and puts random noise on inputs outside their wait windows.
// -----------------------------------------------------------------------------
module tb_gcn_fetch_scheduler;

  localparam int NR = 6;
  localparam int NW = 3;
  localparam int NC = 6;
  localparam int AW = 13;
  localparam int WB = 0;
  localparam int FB = 512;
  localparam int ROW_BW = $clog2(NR);
  localparam int WT_BW  = $clog2(NW);
  localparam int COO_BW = $clog2(NC);

  localparam int K_RD = 0, K_WT = 1, K_FEAT = 2, K_MAC = 3, K_COO = 4, K_ARG = 5, K_DONE = 6;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              mac_done;
  logic              argmax_done;
  logic [AW-1:0]     read_address;
  logic              enable_read;
  logic              wt_we;
  logic [WT_BW-1:0]  wt_idx;
  logic              feat_we;
  logic [ROW_BW-1:0] row_idx;
  logic              mac_start;
  logic [COO_BW-1:0] coo_address;
  logic              coo_valid;
  logic              argmax_start;
  logic              busy;
  logic              done;
  logic [15:0]       cycle_count;

  gcn_fetch_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .mac_done     (mac_done),
    .argmax_done  (argmax_done),
    .read_address (read_address),
    .enable_read  (enable_read),
    .wt_we        (wt_we),
    .wt_idx       (wt_idx),
    .feat_we      (feat_we),
    .row_idx      (row_idx),
    .mac_start    (mac_start),
    .coo_address  (coo_address),
    .coo_valid    (coo_valid),
    .argmax_start (argmax_start),
    .busy         (busy),
    .done         (done),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t   q[7][$];
  string kname[7] = '{"read_address", "wt_idx", "feat_row", "mac_row", "coo_address", "argmax_row", "done_cycle_count"};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit exp_busy[int];
  bit mac_force[int];
  bit arg_force[int];
  bit start_force[int];
  int wr[NR];
  bit noise = 1'b0;
  bit hold_start = 1'b0;
  bit chk_zero = 1'b0;
  bit prev_done = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void push(int k, int c, int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    q[k].push_back(e);
  endfunction

  function automatic void pop_cmp(int k, int v);
    ev_t e;
    n_checks++;
    if (q[k].size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected strobe at cycle %0d (value %0d), none expected", kname[k], cyc, v);
    end else begin
      e = q[k].pop_front();
      if (e.cyc != cyc || e.val != v) begin
        n_fail++;
        $display("FAIL %s: got cycle %0d value %0d, expected cycle %0d value %0d",
                 kname[k], cyc, v, e.cyc, e.val);
      end
    end
  endfunction

  // Reference timeline for one run whose first FETCH_WT cycle is t0.
  // Weight fetch: NW cycles. Each row: fetch, capture, request, then wr[r]
  // wait cycles. Edge walk: NC cycles. Then argmax request and a wait of a.
  function automatic int plan(input int t0, input int a, output int tcoo);
    int t;
    int tdone;
    for (int c = 0; c < NW; c++) begin
      push(K_RD, t0 + c, WB + c);
      push(K_WT, t0 + c + 1, c);
    end
    t = t0 + NW;
    for (int r = 0; r < NR; r++) begin
      push(K_RD, t, FB + r);
      push(K_FEAT, t + 1, r);
      push(K_MAC, t + 2, r);
      for (int k = 1; k <= wr[r]; k++) mac_force[t + 2 + k] = (k == wr[r]);
      t += 3 + wr[r];
    end
    tcoo = t;
    for (int e = 0; e < NC; e++) push(K_COO, t + e, e);
    t += NC;
    push(K_ARG, t, NR - 1);
    for (int k = 1; k <= a; k++) arg_force[t + k] = (k == a);
    tdone = t + 1 + a;
    for (int i = t0; i < tdone; i++) exp_busy[i] = 1'b1;
`ifdef GCN_SCHED_PERF_EN
    push(K_DONE, tdone, tdone - t0);
`else
    push(K_DONE, tdone, 0);
`endif
    return tdone;
  endfunction

  // Drop every expectation from cycle 'now' onward (used on a mid-run reset).
  function automatic void truncate(int now);
    for (int k = 0; k < 7; k++)
      while (q[k].size() > 0 && q[k][$].cyc >= now) void'(q[k].pop_back());
    for (int i = now; i < now + 1000; i++) begin
      exp_busy.delete(i);
      mac_force.delete(i);
      arg_force.delete(i);
      start_force.delete(i);
    end
  endfunction

  // Monitor: compare every DUT strobe against the scoreboard.
  always @(negedge clk) begin
    if (chk_zero)
      chk("outputs_zero", ({read_address, enable_read, wt_we, wt_idx, feat_we, row_idx, mac_start,
                            coo_address, coo_valid, argmax_start, busy, done, cycle_count} == '0) ? 0 : 1, 0);
    chk("busy", int'(busy), exp_busy.exists(cyc) ? 1 : 0);
    if (enable_read) pop_cmp(K_RD, int'(read_address));
    if (wt_we) pop_cmp(K_WT, int'(wt_idx));
    if (feat_we) begin
      pop_cmp(K_FEAT, int'(row_idx));
      chk("feat_we_with_enable_read", int'(enable_read), 0);
    end
    if (mac_start) pop_cmp(K_MAC, int'(row_idx));
    if (coo_valid) pop_cmp(K_COO, int'(coo_address));
    if (argmax_start) pop_cmp(K_ARG, int'(row_idx));
    if (done && !prev_done) pop_cmp(K_DONE, int'(cycle_count));
    prev_done <= done;
  end

  task automatic step();
    @(posedge clk);
    #1;
    start = start_force.exists(cyc) ||
            (exp_busy.exists(cyc) && (hold_start || (noise && ($urandom_range(0, 1) == 1))));
    mac_done    = mac_force.exists(cyc) ? mac_force[cyc] : (noise && ($urandom_range(0, 1) == 1));
    argmax_done = arg_force.exists(cyc) ? arg_force[cyc] : (noise && ($urandom_range(0, 1) == 1));
  endtask

  task automatic set_wr(input int w);
    for (int r = 0; r < NR; r++) wr[r] = w;
  endtask

  task automatic abort_now();
    truncate(cyc);
    reset_n  = 1'b0;
    chk_zero = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    chk_zero = 1'b0;
  endtask

  // abort_kind: 0 none, 1 reset in third COO_WALK cycle, 2 reset in last FETCH_WT cycle
  task automatic do_run(input int a, input bit nz, input int abort_kind);
    int t0;
    int tdone;
    int tcoo;
    int tab;
    noise = nz;
    t0 = cyc + 2;
    start_force[t0 - 1] = 1'b1;
    tdone = plan(t0, a, tcoo);
    tab = (abort_kind == 1) ? tcoo + 2 : ((abort_kind == 2) ? t0 + NW - 1 : -1);
    while (cyc < tdone + 2) begin
      step();
      if (cyc == tab) begin
        abort_now();
        break;
      end
    end
    noise = 1'b0;
  endtask

  initial begin
    int t0;
    int td1;
    int td2;
    int tc;
    reset_n     = 1'b0;
    start       = 1'b0;
    mac_done    = 1'b0;
    argmax_done = 1'b0;
    chk_zero    = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (10) step();
    chk_zero = 1'b0;

    // Nominal run: 35 cycles.
    set_wr(1);
    do_run(1, 1'b0, 0);

    // Row 2 multiply takes 5 wait cycles: 39 cycles total.
    set_wr(1);
    wr[2] = 5;
    do_run(1, 1'b0, 0);

    // Random latencies with input noise outside the wait windows.
    for (int n = 0; n < 4; n++) begin
      for (int r = 0; r < NR; r++) wr[r] = $urandom_range(1, 4);
      do_run($urandom_range(1, 3), 1'b1, 0);
    end

    // start held high: no restart while busy, one DONE cycle, then restart.
    set_wr(1);
    hold_start = 1'b1;
    t0 = cyc + 2;
    start_force[t0 - 1] = 1'b1;
    td1 = plan(t0, 1, tc);
    start_force[td1] = 1'b1;
    td2 = plan(td1 + 1, 1, tc);
    while (cyc < td2 + 2) step();
    hold_start = 1'b0;
    repeat (2) step();

    // Reset during COO_WALK, then a fresh run.
    set_wr(1);
    do_run(1, 1'b1, 1);
    do_run(1, 1'b0, 0);

    // Reset on the last weight read: the trailing wt_we must not appear.
    do_run(1, 1'b0, 2);
    do_run(2, 1'b1, 0);

    repeat (3) step();
    for (int k = 0; k < 7; k++) begin
      chk({"pending_", kname[k]}, q[k].size(), 0);
      while (q[k].size() > 0) begin
        ev_t e;
        e = q[k].pop_front();
        $display("FAIL %s missing strobe: expected at cycle %0d value %0d, not seen", kname[k], e.cyc, e.val);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
